// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pipe_pkg
//  Description : Shared definitions for the MEM/WB end of the pipeline:
//                default datapath width, MEM-stage FSM encoding and the
//                bubble (NOP) values loaded into the MEM/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    // Default datapath width (data and ALU result)
    localparam int DATA_W = 32;

    // MEM-stage access state machine
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Bubble values for the MEM/WB control fields; data fields bubble to '0
    localparam logic [4:0] BUBBLE_RW       = 5'd0;
    localparam logic       BUBBLE_REGWRITE = 1'b0;
    localparam logic       BUBBLE_MEMTOREG = 1'b0;

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_reg
//  Description : MEM/WB pipeline register. Falling-edge state, synchronous
//                reset, bubble insert (higher priority) and load enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_reg #(
    parameter int DATA_W = mips_pipe_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic [4:0]        rw_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [4:0]        rw_o,
    output logic              regwrite_o,
    output logic              memtoreg_o,
    output logic [DATA_W-1:0] alu_out_o,
    output logic [DATA_W-1:0] mem_data_o
);
    import mips_pipe_pkg::*;

    logic [4:0]        rw_q;
    logic              regwrite_q;
    logic              memtoreg_q;
    logic [DATA_W-1:0] alu_out_q;
    logic [DATA_W-1:0] mem_data_q;

    // Reset clears, bubble inserts a NOP, load captures, otherwise hold
    always_ff @(negedge clk) begin
        if (Reset || bubble_i) begin
            rw_q       <= BUBBLE_RW;
            regwrite_q <= BUBBLE_REGWRITE;
            memtoreg_q <= BUBBLE_MEMTOREG;
            alu_out_q  <= '0;
            mem_data_q <= '0;
        end else if (load_i) begin
            rw_q       <= rw_i;
            regwrite_q <= regwrite_i;
            memtoreg_q <= memtoreg_i;
            alu_out_q  <= alu_out_i;
            mem_data_q <= mem_data_i;
        end
    end

    assign rw_o       = rw_q;
    assign regwrite_o = regwrite_q;
    assign memtoreg_o = memtoreg_q;
    assign alu_out_o  = alu_out_q;
    assign mem_data_o = mem_data_q;

endmodule : mem_wb_reg
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : MEM stage. Runs the data-memory access for the EX/MEM
//                instruction over a ready/valid port, stalls upstream during
//                wait states, aborts after TIMEOUT wait cycles and fills the
//                MEM/WB register that drives the writeback bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int DATA_W  = mips_pipe_pkg::DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Data_Memory_Input_EX_MEM,
    input  logic [DATA_W-1:0] ALU_OUT_EX_MEM,
    input  logic [4:0]        RW_EX_MEM,
    input  logic              MemToReg_EX_MEM,
    input  logic              RegWrite_EX_MEM,
    input  logic              MemRead_EX_MEM,
    input  logic              MemWrite_EX_MEM,
    input  logic              DataMemForwardCtrl_MEM_EX_MEM,
    output logic              Mem_Req,
    output logic              Mem_WE,
    output logic [DATA_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic              Mem_Ready,
    input  logic [DATA_W-1:0] Mem_RData,
    output logic              Stall_MEM,
    output logic              Mem_Error,
    output logic [4:0]        RW_MEM_WB,
    output logic              RegWrite_MEM_WB,
    output logic              MemToReg_MEM_WB,
    output logic [DATA_W-1:0] ALU_OUT_MEM_WB,
    output logic [DATA_W-1:0] Mem_Data_MEM_WB,
    output logic [DATA_W-1:0] BusW_MEM_WB
);
    import mips_pipe_pkg::*;

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              req_we_q;
    logic [DATA_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;

    logic              w_access;
    logic              w_latch;
    logic              w_load;
    logic              w_bubble;
    logic              w_regwrite;
    logic [DATA_W-1:0] w_alu_out;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] w_issue_wdata;

    assign w_access      = MemRead_EX_MEM | MemWrite_EX_MEM;
    // Forwarded store data is taken from the current writeback bus at issue
    assign w_issue_wdata = DataMemForwardCtrl_MEM_EX_MEM ? BusW_MEM_WB
                                                         : Data_Memory_Input_EX_MEM;

    // Next-state, memory port, stall and MEM/WB load/bubble decisions
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        w_latch    = 1'b0;
        w_load     = 1'b0;
        w_bubble   = 1'b0;
        w_regwrite = RegWrite_EX_MEM;
        w_alu_out  = ALU_OUT_EX_MEM;
        w_mem_data = '0;
        Mem_Req    = 1'b0;
        Mem_WE     = MemWrite_EX_MEM;
        Mem_Addr   = ALU_OUT_EX_MEM;
        Mem_WData  = w_issue_wdata;
        Stall_MEM  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (w_access) begin
                    Mem_Req = 1'b1;
                    if (Mem_Ready) begin
                        // Zero-wait access completes in the issue cycle
                        w_load     = 1'b1;
                        w_mem_data = MemWrite_EX_MEM ? '0 : Mem_RData;
                    end else begin
                        Stall_MEM = 1'b1;
                        w_bubble  = 1'b1;
                        w_latch   = 1'b1;
                        cnt_d     = '0;
                        state_d   = WAIT;
                    end
                end else begin
                    w_load = 1'b1;
                end
            end
            WAIT: begin
                // Memory sees only the request captured at issue
                Mem_Req   = 1'b1;
                Mem_WE    = req_we_q;
                Mem_Addr  = req_addr_q;
                Mem_WData = req_wdata_q;
                w_alu_out = req_addr_q;
                if (Mem_Ready) begin
                    w_load     = 1'b1;
                    w_mem_data = req_we_q ? '0 : Mem_RData;
                    state_d    = IDLE;
                end else if (cnt_q == C_TIMEOUT) begin
                    // Abort: retire the instruction without a register write
                    w_load     = 1'b1;
                    w_regwrite = 1'b0;
                    err_d      = 1'b1;
                    state_d    = IDLE;
                end else begin
                    Stall_MEM = 1'b1;
                    w_bubble  = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (Reset) begin
            Mem_Req   = 1'b0;
            Stall_MEM = 1'b0;
        end
    end

    // FSM state, wait counter, sticky error and issue-time request latch
    always_ff @(negedge clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (w_latch) begin
                req_we_q    <= MemWrite_EX_MEM;
                req_addr_q  <= ALU_OUT_EX_MEM;
                req_wdata_q <= w_issue_wdata;
            end
        end
    end

    assign Mem_Error = err_q;

    mem_wb_reg #(
        .DATA_W (DATA_W)
    ) u_mem_wb_reg (
        .clk        (clk),
        .Reset      (Reset),
        .load_i     (w_load),
        .bubble_i   (w_bubble),
        .rw_i       (RW_EX_MEM),
        .regwrite_i (w_regwrite),
        .memtoreg_i (MemToReg_EX_MEM),
        .alu_out_i  (w_alu_out),
        .mem_data_i (w_mem_data),
        .rw_o       (RW_MEM_WB),
        .regwrite_o (RegWrite_MEM_WB),
        .memtoreg_o (MemToReg_MEM_WB),
        .alu_out_o  (ALU_OUT_MEM_WB),
        .mem_data_o (Mem_Data_MEM_WB)
    );

    assign BusW_MEM_WB = MemToReg_MEM_WB ? Mem_Data_MEM_WB : ALU_OUT_MEM_WB;

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Directed self-checking bench for mem_wb_stage. Inputs change
//                1ns after the falling (active) edge; outputs are checked
//                1ns after that (combinational) or 1ns after the next edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          Reset;
    logic [DW-1:0] din, alu, rdata;
    logic [4:0]    rw;
    logic          m2r, regw, mrd, mwr, fwd, ready;
    logic          Mem_Req, Mem_WE, Stall_MEM, Mem_Error;
    logic [DW-1:0] Mem_Addr, Mem_WData;
    logic [4:0]    RW_MEM_WB;
    logic          RegWrite_MEM_WB, MemToReg_MEM_WB;
    logic [DW-1:0] ALU_OUT_MEM_WB, Mem_Data_MEM_WB, BusW_MEM_WB;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(DW), .TIMEOUT(15)) dut (
        .clk                           (clk),
        .Reset                         (Reset),
        .Data_Memory_Input_EX_MEM      (din),
        .ALU_OUT_EX_MEM                (alu),
        .RW_EX_MEM                     (rw),
        .MemToReg_EX_MEM               (m2r),
        .RegWrite_EX_MEM               (regw),
        .MemRead_EX_MEM                (mrd),
        .MemWrite_EX_MEM               (mwr),
        .DataMemForwardCtrl_MEM_EX_MEM (fwd),
        .Mem_Req                       (Mem_Req),
        .Mem_WE                        (Mem_WE),
        .Mem_Addr                      (Mem_Addr),
        .Mem_WData                     (Mem_WData),
        .Mem_Ready                     (ready),
        .Mem_RData                     (rdata),
        .Stall_MEM                     (Stall_MEM),
        .Mem_Error                     (Mem_Error),
        .RW_MEM_WB                     (RW_MEM_WB),
        .RegWrite_MEM_WB               (RegWrite_MEM_WB),
        .MemToReg_MEM_WB               (MemToReg_MEM_WB),
        .ALU_OUT_MEM_WB                (ALU_OUT_MEM_WB),
        .Mem_Data_MEM_WB               (Mem_Data_MEM_WB),
        .BusW_MEM_WB                   (BusW_MEM_WB)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next active (falling) edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [DW-1:0] a, input logic [DW-1:0] d, input logic [4:0] r,
                          input logic mr, input logic mw, input logic m2, input logic rg,
                          input logic f);
        alu = a; din = d; rw = r; mrd = mr; mwr = mw; m2r = m2; regw = rg; fwd = f;
    endtask

    initial begin
        Reset = 1'b1; ready = 1'b0; rdata = '0;
        set_ex(32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_req", Mem_Req, 0);
        chk("rst_stall", Stall_MEM, 0);
        tick(); tick();
        chk("rst_rw", RW_MEM_WB, 0);
        chk("rst_busw", BusW_MEM_WB, 0);
        chk("rst_err", Mem_Error, 0);
        chk("rst_regw", RegWrite_MEM_WB, 0);
        Reset = 1'b0;

        // Zero-wait load
        set_ex(32'h100, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        ready = 1'b1; rdata = 32'hDEADBEEF;
        #1;
        chk("zw_req", Mem_Req, 1);
        chk("zw_we", Mem_WE, 0);
        chk("zw_addr", Mem_Addr, 32'h100);
        chk("zw_stall", Stall_MEM, 0);
        tick();
        chk("zw_rw", RW_MEM_WB, 5);
        chk("zw_regw", RegWrite_MEM_WB, 1);
        chk("zw_busw", BusW_MEM_WB, 32'hDEADBEEF);

        // ALU-only with a stray Mem_Ready that must be ignored
        set_ex(32'h55, 32'h0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ready = 1'b1; rdata = 32'hFFFF_FFFF;
        #1;
        chk("alu_req", Mem_Req, 0);
        chk("alu_stall", Stall_MEM, 0);
        tick();
        chk("alu_busw", BusW_MEM_WB, 32'h55);
        chk("alu_mdata", Mem_Data_MEM_WB, 0);

        // ALU-only producing the value to be forwarded
        set_ex(32'h1234, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ready = 1'b0;
        tick();
        chk("pre_busw", BusW_MEM_WB, 32'h1234);

        // 3-wait store with forwarded data
        set_ex(32'h200, 32'hAAAA, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("st_req", Mem_Req, 1);
        chk("st_we", Mem_WE, 1);
        chk("st_addr", Mem_Addr, 32'h200);
        chk("st_wd0", Mem_WData, 32'h1234);
        chk("st_stall0", Stall_MEM, 1);
        tick();
        chk("st_bubble_regw", RegWrite_MEM_WB, 0);
        chk("st_bubble_busw", BusW_MEM_WB, 0);
        chk("st_wd1", Mem_WData, 32'h1234);
        chk("st_stall1", Stall_MEM, 1);
        tick();
        chk("st_wd2", Mem_WData, 32'h1234);
        chk("st_stall2", Stall_MEM, 1);
        tick();
        ready = 1'b1;
        #1;
        chk("st_wd3", Mem_WData, 32'h1234);
        chk("st_stall3", Stall_MEM, 0);
        chk("st_req3", Mem_Req, 1);
        tick();
        chk("st_alu_wb", ALU_OUT_MEM_WB, 32'h200);
        chk("st_mdata", Mem_Data_MEM_WB, 0);
        chk("st_regw", RegWrite_MEM_WB, 0);

        // Timeout on a load: 16 stall cycles, then abort
        set_ex(32'h300, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        ready = 1'b0; rdata = 32'h1111_2222;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("to_stall%0d", i), Stall_MEM, 1);
            tick();
        end
        #1;
        chk("to_stall_end", Stall_MEM, 0);
        chk("to_req_end", Mem_Req, 1);
        chk("to_err_pre", Mem_Error, 0);
        tick();
        chk("to_err", Mem_Error, 1);
        chk("to_regw", RegWrite_MEM_WB, 0);
        chk("to_rw", RW_MEM_WB, 9);
        chk("to_mdata", Mem_Data_MEM_WB, 0);

        // Next instruction proceeds; error stays sticky
        set_ex(32'h77, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("nx_stall", Stall_MEM, 0);
        tick();
        chk("nx_busw", BusW_MEM_WB, 32'h77);
        chk("nx_regw", RegWrite_MEM_WB, 1);
        chk("nx_err", Mem_Error, 1);

        // Read and write both set: treated as a write
        set_ex(32'h400, 32'hBBBB, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ready = 1'b1; rdata = 32'hCAFE;
        #1;
        chk("rw_we", Mem_WE, 1);
        chk("rw_wd", Mem_WData, 32'hBBBB);
        chk("rw_stall", Stall_MEM, 0);
        tick();
        chk("rw_mdata", Mem_Data_MEM_WB, 0);
        chk("rw_busw", BusW_MEM_WB, 0);

        // Reset in the second WAIT cycle
        set_ex(32'h500, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        ready = 1'b0;
        tick();
        tick();
        #1;
        chk("mr_stall_pre", Stall_MEM, 1);
        Reset = 1'b1;
        #1;
        chk("mr_req", Mem_Req, 0);
        chk("mr_stall", Stall_MEM, 0);
        tick();
        chk("mr_rw", RW_MEM_WB, 0);
        chk("mr_alu", ALU_OUT_MEM_WB, 0);
        chk("mr_busw", BusW_MEM_WB, 0);
        chk("mr_regw", RegWrite_MEM_WB, 0);
        chk("mr_err", Mem_Error, 0);
        Reset = 1'b0;
        mrd = 1'b0;
        #1;
        chk("mr_idle_req", Mem_Req, 0);
        chk("mr_idle_stall", Stall_MEM, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_wb_stage
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline interface.
- Takes the EX/MEM register outputs and runs the data-memory access over a ready/valid memory port. Memory may add wait states; while it does, the block stalls the upstream pipe.
- Registers the result into the MEM/WB pipeline register and produces the writeback bus.

Parameters:
- DATA_W, 32, data and ALU result width.
- TIMEOUT, 15, max WAIT cycles before the access is aborted. Valid range 1..255.

Ports:
- clk  in  1  pipeline clock. All state updates on the falling edge, matching the pipeline registers.
- Reset  in  1  synchronous active-high reset, sampled on the clk falling edge.
- Data_Memory_Input_EX_MEM  in  DATA_W  store data from EX/MEM.
- ALU_OUT_EX_MEM  in  DATA_W  ALU result; this is the memory address for loads and stores.
- RW_EX_MEM  in  5  destination register.
- MemToReg_EX_MEM, RegWrite_EX_MEM, MemRead_EX_MEM, MemWrite_EX_MEM  in  1 each  control bits.
- DataMemForwardCtrl_MEM_EX_MEM  in  1  when 1, store data comes from BusW_MEM_WB, not from Data_Memory_Input_EX_MEM.
- Mem_Req  out  1  memory request valid.
- Mem_WE  out  1  1 = write.
- Mem_Addr  out  DATA_W  request address.
- Mem_WData  out  DATA_W  write data.
- Mem_Ready  in  1  memory completes the request this cycle.
- Mem_RData  in  DATA_W  read data, valid when Mem_Ready=1.
- Stall_MEM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- Mem_Error  out  1  sticky timeout flag.
- RW_MEM_WB  out  5  MEM/WB destination register.
- RegWrite_MEM_WB, MemToReg_MEM_WB  out  1 each  MEM/WB control bits.
- ALU_OUT_MEM_WB, Mem_Data_MEM_WB  out  DATA_W  MEM/WB ALU result and load data.
- BusW_MEM_WB  out  DATA_W  writeback value.

Behaviour:
- Definitions:
  - access = MemRead_EX_MEM | MemWrite_EX_MEM.
  - wr = MemWrite_EX_MEM. If both MemRead and MemWrite are set, the access is a write.
- States: IDLE, WAIT.
- IDLE, no access:
  - Mem_Req=0, Stall_MEM=0.
  - MEM/WB captures the EX/MEM fields; Mem_Data_MEM_WB=0.
- IDLE, access:
  - Mem_Req=1 combinationally, Mem_WE=wr, Mem_Addr=ALU_OUT_EX_MEM.
  - Mem_WData = DataMemForwardCtrl ? BusW_MEM_WB : Data_Memory_Input_EX_MEM.
- IDLE, access with Mem_Ready=1 (zero-wait):
  - No stall.
  - MEM/WB captures the fields; Mem_Data_MEM_WB=Mem_RData for reads, 0 for writes.
- IDLE, access with Mem_Ready=0:
  - Stall_MEM=1.
  - Latch req_we, req_addr and req_wdata. The forwarded store value is latched at issue, because MEM/WB is bubbled afterwards.
  - Clear the counter; go to WAIT.
  - MEM/WB gets a bubble: RegWrite_MEM_WB=0, MemToReg_MEM_WB=0, other fields 0.
- WAIT:
  - Mem_Req=1, driven from the latched values only; EX/MEM inputs are ignored.
  - Stall_MEM = ~Mem_Ready.
  - Each non-ready cycle: bubble into MEM/WB, counter+1.
- WAIT, Mem_Ready=1:
  - MEM/WB captures the held EX/MEM fields plus Mem_RData for a read; go to IDLE.
  - Stall_MEM=0 that cycle, so the next instruction advances on the same edge.
- WAIT, timeout: counter reaches TIMEOUT with Mem_Ready=0:
  - Mem_Error is set and stays set until Reset.
  - Go to IDLE; Stall_MEM=0 that cycle.
  - MEM/WB captures the instruction with RegWrite_MEM_WB forced 0. The aborted load never writes the register file.
- A Mem_Ready arriving in IDLE with Mem_Req=0 is ignored.
- Back-to-back accesses: after a WAIT completes, the next access is evaluated from IDLE on the following cycle. Mem_Req may therefore stay high across consecutive requests.
- BusW_MEM_WB = MemToReg_MEM_WB ? Mem_Data_MEM_WB : ALU_OUT_MEM_WB. Purely combinational from MEM/WB state.
- Reset, effective on the edge it is sampled, including mid-WAIT:
  - state=IDLE, counter=0, Mem_Error=0.
  - All MEM/WB outputs 0; latched request values 0.
  - While Reset=1: Mem_Req=0, Stall_MEM=0.
- Latency: one clk edge from EX/MEM to MEM/WB, plus N edges for N memory wait states.

Decomposition:
- Shared package mips_pipe_pkg:
  - DATA_W; the state encoding (IDLE=1'b0, WAIT=1'b1); the bubble value for the MEM/WB fields.
- One natural sub-module, mem_wb_reg: the MEM/WB register with load-enable and bubble-insert controls.
- The FSM, request latch and timeout counter stay in mem_wb_stage. Counter width is $clog2(TIMEOUT+1).

Test Plan:
- Zero-wait load: MemRead=1, ALU_OUT=0x100, RW=5, MemToReg=1, RegWrite=1; Mem_Ready tied 1, Mem_RData=0xDEADBEEF -> no stall; next edge RW_MEM_WB=5, BusW_MEM_WB=0xDEADBEEF.
- 3-wait store with forwarding: DataMemForwardCtrl=1, BusW_MEM_WB=0x1234, then MEM/WB bubbles -> Mem_WData stays 0x1234 for 4 cycles; Stall_MEM high 3 cycles; RegWrite_MEM_WB=0 during the stall.
- ALU-only instruction: ALU_OUT=0x55, RegWrite=1, MemToReg=0 -> Mem_Req=0; BusW_MEM_WB=0x55 after one edge.
- Timeout: load with Mem_Ready held 0, TIMEOUT=15 -> Stall_MEM high 16 cycles; Mem_Error=1 afterwards; RegWrite_MEM_WB=0; next instruction proceeds.
- Reset in cycle 2 of WAIT -> Mem_Req=0 and Stall_MEM=0 immediately; all MEM/WB outputs 0 after the edge; Mem_Error=0.
- MemRead=MemWrite=1 with Mem_Ready=1 -> Mem_WE=1; Mem_Data_MEM_WB=0.
